// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and receiver.
//   uart_tx_state_t  transmitter FSM states (IDLE, START, DATA, PARITY, STOP)
//   UART_DATA_BITS   data bits per frame
//   UART_FRAME_BITS  total bits per frame; 11 when UART_TX_PARITY_EN is defined, else 10
//   even_parity()    XOR of the data bits
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = UART_DATA_BITS + 3;
`else
    localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;
`endif

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous single-clock byte FIFO for the UART transmitter.
//   clk, rst      clock, synchronous active-high reset (clears pointers and count)
//   wr, wr_data   write strobe and byte; ignored while full
//   rd, rd_data   pop strobe and head byte (rd_data valid whenever not empty); ignored while empty
//   full, empty   occupancy flags derived from the registered count
//   count         number of stored entries
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr,
    input  logic [7:0]                      wr_data,
    input  logic                            rd,
    output logic [7:0]                      rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr, do_rd;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a write arriving while full
    // is dropped even when a pop frees a slot in the same cycle.
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, LSB first, start/stop framing, back-to-back frames.
// Optional even parity bit after data bit 7 when UART_TX_PARITY_EN is defined (11-bit frame);
// default build is 8N1 (10-bit frame).
//   CLKS_PER_BIT  clocks per bit (>= 2), FIFO_DEPTH  FIFO entries (power of two, >= 2)
//   clk, rst      clock, synchronous active-high reset
//   tx_wr, tx_data  write strobe and byte, accepted when tx_full is low
//   tx_full       FIFO full
//   tx_busy       frame in progress or FIFO non-empty
//   tx_done       one-cycle pulse on the last clock of each stop bit
//   txd           registered serial output, idle high
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

    localparam int          CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic          fifo_rd;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;

    uart_tx_state_t state_q, state_d;
    logic [15:0]    clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           txd_q, txd_d;
    logic           tx_done_q, tx_done_d;
    logic           bit_end;
`ifdef UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (tx_wr),
        .wr_data (tx_data),
        .rd      (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (tx_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // txd and tx_done are registered from the current state, so the line
    // follows the FSM by one clock: START entered at N+1 shows on txd at N+2,
    // and tx_done lines up with the final clock of the stop bit on txd.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        txd_d     = 1'b1;
        tx_done_d = 1'b0;
        fifo_rd   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_end   = (clk_cnt_q == BIT_LAST);
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    shreg_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_rd_data);
`endif
                    state_d = START;
                end
            end

            START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end

            DATA: begin
                txd_d = shreg_q[0];
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd_d = parity_q;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    tx_done_d = 1'b1;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        shreg_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_rd_data);
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            txd_q     <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign txd     = txd_q;
    assign tx_done = tx_done_q;
    assign tx_busy = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A frame-level reference model tracks the queued bytes and the remaining frame time,
// predicting txd/tx_done/tx_busy/tx_full each cycle and pushing every byte it starts
// sending into a scoreboard queue; an independent line receiver decodes txd and pops
// that queue. Honours UART_TX_PARITY_EN.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FB    = UART_FRAME_BITS;
    localparam int FBT   = FB * CPB;

    logic       clk;
    logic       rst;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       tx_busy;
    logic       tx_done;
    logic       txd;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_wr   (tx_wr),
        .tx_data (tx_data),
        .tx_full (tx_full),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .txd     (txd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bits in line order: index 0 is the start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  m_q[$];
    logic [7:0]  expq[$];
    int          m_rem = 0;       // frame clocks left, counting the current one
    int          m_sz0;
    logic [10:0] m_fbits = '1;
    logic [7:0]  m_b;
    logic        e_txd = 1'b1;
    logic        e_done = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            expq.delete();
            m_rem  = 0;
            e_txd  = 1'b1;
            e_done = 1'b0;
        end else begin
            m_sz0  = m_q.size();
            e_txd  = (m_rem > 0) ? m_fbits[(FBT - m_rem) / CPB] : 1'b1;
            e_done = (m_rem == 1);
            if (m_rem <= 1 && m_q.size() > 0) begin
                m_b     = m_q.pop_front();
                m_fbits = frame_of(m_b);
                m_rem   = FBT;
                expq.push_back(m_b);
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (tx_wr && m_sz0 < DEPTH) m_q.push_back(tx_data);
        end
    end

    // ---------------- cycle checker ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("txd", {31'd0, txd}, {31'd0, e_txd});
            chk("tx_done", {31'd0, tx_done}, {31'd0, e_done});
            chk("tx_busy", {31'd0, tx_busy}, {31'd0, (m_rem > 0 || m_q.size() > 0)});
            chk("tx_full", {31'd0, tx_full}, {31'd0, (m_q.size() == DEPTH)});
        end
    end

    // ---------------- line receiver / scoreboard monitor ----------------
    bit          rx_active = 0;
    int          rx_cnt = 0;
    logic [10:0] rx_bits = '1;
    logic [7:0]  rx_byte;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (txd === 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_bits[rx_cnt / CPB] = txd;
                if (rx_cnt / CPB == FB - 1) begin
                    rx_active = 0;
                    rx_byte   = rx_bits[8:1];
                    chk("rx_start", {31'd0, rx_bits[0]}, 32'd0);
                    chk("rx_stop", {31'd0, rx_bits[FB-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
                    chk("rx_parity", {31'd0, rx_bits[9]}, {31'd0, ^rx_byte});
`endif
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rx_unexpected: got byte %02h, expected no frame at %0t", rx_byte, $time);
                    end else begin
                        chk("rx_byte", {24'd0, rx_byte}, {24'd0, expq.pop_front()});
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic wr, input logic [7:0] d);
        tx_wr   = wr;
        tx_data = d;
        @(posedge clk);
        #1;
        tx_wr   = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_idle(input int max_cycles);
        bit idle;
        idle = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (m_rem == 0 && m_q.size() == 0 && !rx_active) begin
                idle = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        if (!idle) begin
            fails++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", max_cycles);
        end
    endtask

    initial begin
        rst     = 1'b1;
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        @(posedge clk);
        #1;
        chk_en = 1;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_busy", {31'd0, tx_busy}, 32'd0);
        chk("reset_full", {31'd0, tx_full}, 32'd0);
        chk("reset_done", {31'd0, tx_done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single byte
        step(1'b1, 8'h55);
        wait_idle(200);

        // back-to-back pair
        step(1'b1, 8'hA3);
        step(1'b1, 8'h0F);
        wait_idle(300);

        // overflow burst
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i));
        wait_idle(600);

        // reset in the middle of a 0x00 frame with bytes queued
        step(1'b1, 8'h00);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        repeat (17) step(1'b0, 8'h00);
        rst = 1'b1;
        step(1'b0, 8'h00);
        chk("rst_mid_txd", {31'd0, txd}, 32'd1);
        chk("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
        rst = 1'b0;
        repeat (3 * FBT) step(1'b0, 8'h00);

        // parity-relevant bytes plus boundary patterns
        step(1'b1, 8'h07);
        step(1'b1, 8'h03);
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        wait_idle(600);
        step(1'b1, 8'h5A);
        wait_idle(200);

        // random traffic with occasional bursts
        repeat (800) begin
            if ($urandom_range(0, 40) == 0) begin
                repeat (5) step(1'b1, 8'($urandom));
            end else begin
                step(($urandom_range(0, 5) == 0), 8'($urandom));
            end
        end
        wait_idle(2000);
        chk("scoreboard_drained", expq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
